// File: rtl/rtop_pkg.sv
// Shared encodings and widths for the rectangular-to-polar scheduler.
package rtop_pkg;
  localparam int OPW  = 4;   // X/Y operand width
  localparam int RESW = 8;   // magnitude/angle width

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CONV = 2'b01,
    ST_HOLD = 2'b10
  } state_t;
endpackage

// File: rtl/RtoPF.sv
// Rectangular-to-polar converter, first quadrant, unsigned 4-bit inputs.
// A     = floor(sqrt(X^2 + Y^2))
// Angle = pseudo-angle floor(64*Y/(X+Y)); 0 maps the +X axis, 64 the +Y axis.
module RtoPF (
  input  logic [3:0] X,
  input  logic [3:0] Y,
  output logic [7:0] A,
  output logic [7:0] Angle
);
  logic [8:0] sum_sq;
  logic [9:0] num;
  logic [4:0] den;

  assign sum_sq = 9'(X * X) + 9'(Y * Y);
  assign num    = {Y, 6'b0};
  assign den    = {1'b0, X} + {1'b0, Y};

  // integer square root by exhaustive compare; largest root is 21 (15,15)
  always_comb begin
    A = '0;
    for (int r = 1; r < 22; r++)
      if (r * r <= int'(sum_sq)) A = 8'(r);
  end

  // origin has no direction; report 0 rather than divide by zero
  always_comb begin
    Angle = '0;
    if (den != '0) Angle = 8'(num / {5'd0, den});
  end
endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx
);
  // rotate the search start to ptr and stop at the first hit
  always_comb begin
    logic found;
    int   j;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (en && !found && req[j]) begin
        grant[j] = 1'b1;
        idx      = IDW'(j);
        found    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rtop_scheduler.sv
// Time-shares one RtoPF converter between NREQ valid/ready requesters.
module rtop_scheduler
  import rtop_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int IDW      = 2,
  parameter int CONV_LAT = 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [OPW*NREQ-1:0] req_x,
  input  logic [OPW*NREQ-1:0] req_y,
  output logic [NREQ-1:0]     req_ready,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [IDW-1:0]      res_id,
  output logic [RESW-1:0]     res_mag,
  output logic [RESW-1:0]     res_angle,
  output logic                busy
);
  localparam int CW = $clog2(CONV_LAT) + 1;

  state_t          state;
  logic [IDW-1:0]  rr_ptr;
  logic [CW-1:0]   counter;
  logic [OPW-1:0]  op_x, op_y;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  gidx;
  logic [RESW-1:0] conv_a, conv_ang;
  logic            arb_en;

  // grants only exist in IDLE, and never while reset is held
  assign arb_en    = RST && (state == ST_IDLE);
  assign req_ready = grant;
  assign busy      = (state != ST_IDLE);

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .en    (arb_en),
    .grant (grant),
    .idx   (gidx)
  );

  RtoPF u_conv (
    .X     (op_x),
    .Y     (op_y),
    .A     (conv_a),
    .Angle (conv_ang)
  );

  // accept -> hold operands CONV_LAT cycles -> present result until taken
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      counter   <= '0;
      op_x      <= '0;
      op_y      <= '0;
      res_id    <= '0;
      res_mag   <= '0;
      res_angle <= '0;
      res_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|grant) begin
            op_x    <= req_x[gidx*OPW +: OPW];
            op_y    <= req_y[gidx*OPW +: OPW];
            res_id  <= gidx;
            rr_ptr  <= (gidx == IDW'(NREQ-1)) ? '0 : gidx + 1'b1;
            counter <= CW'(CONV_LAT - 1);
            state   <= ST_CONV;
          end
        end
        ST_CONV: begin
          if (counter != '0) begin
            counter <= counter - 1'b1;
          end else begin
            res_mag   <= conv_a;
            res_angle <= conv_ang;
            res_valid <= 1'b1;
            state     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          res_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/rtop_scheduler.md
Name: rtop_scheduler

Overview:
- Time-shares one rectangular-to-polar converter (RtoPF) between NREQ requesters.
- Each requester offers a 4-bit X/Y operand pair using a valid/ready handshake.
- A round-robin arbiter picks one request. The block registers its operands, waits CONV_LAT cycles for the converter to settle, then returns magnitude, angle and requester ID on a single valid/ready result port.
- The block sits between the coordinate sources and the output/display logic. It replaces the single-shot load-then-flag sequencing.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester ID width; must equal clog2(NREQ).
- CONV_LAT, 1, cycles operands are held on the converter before the result is captured (>=1).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_x  in  4*NREQ  X operands, unsigned; requester i uses bits [4i+3:4i].
- req_y  in  4*NREQ  Y operands, unsigned, same packing as req_x.
- req_ready  out  NREQ  one-hot accept; at most one bit high in any cycle.
- res_valid  out  1  result valid.
- res_ready  in  1  downstream accepts result.
- res_id  out  IDW  index of the requester that owns the result.
- res_mag  out  8  magnitude from RtoPF output A.
- res_angle  out  8  angle from RtoPF output Angle.
- busy  out  1  high whenever state != IDLE.

Behaviour:
Reset (RST low, takes effect immediately, asynchronous):
- state=IDLE, rr_ptr=0, counter=0.
- Operand registers, res_mag, res_angle and res_id = 0.
- res_valid=0, busy=0, req_ready=0.
- Reset mid-operation discards the in-flight request and any pending result; nothing is replayed.

State machine (2-bit): IDLE, CONV, HOLD. The spare encoding returns to IDLE.
- IDLE:
  - If any req_valid is high, grant g = first set bit searching from rr_ptr upward, wrapping modulo NREQ.
  - req_ready[g]=1 combinationally in this cycle only.
  - At the clock edge: latch req_x[g] and req_y[g] into the operand registers; res_id<=g; rr_ptr<=(g+1) mod NREQ; counter<=CONV_LAT-1; next state CONV.
  - With no req_valid high: stay in IDLE; rr_ptr is unchanged.
- CONV:
  - Operand registers drive RtoPF continuously.
  - counter!=0: decrement.
  - counter==0: res_mag<=A, res_angle<=Angle, res_valid<=1, next state HOLD.
- HOLD:
  - res_valid=1; res_* outputs are stable.
  - When res_ready is high at a clock edge: res_valid<=0, next state IDLE.
  - With res_ready low, hold indefinitely; result data must not change.

Timing and throughput:
- res_valid rises exactly CONV_LAT clock edges after the accept edge.
- req_ready is never asserted outside IDLE. Requests arriving during CONV or HOLD wait.
- Minimum spacing between accepts is CONV_LAT+2 cycles, with res_ready tied high.

Handshake rules:
- Requesters must hold req_valid and operands stable until they see req_ready. The block does not check this.
- A requester dropping valid before it is granted is simply skipped.

Boundary conditions:
- A result handshake in HOLD and a new req_valid in the same cycle: the request is accepted in the following IDLE cycle.
- If rr_ptr points at an idle requester, the search wraps to the next valid one.
- A single requester with continuous valid is served every round.
- Fairness: with all requesters valid, the grant order is 0,1,..,NREQ-1,0.
- Arithmetic: operands and results pass through unchanged; the block performs no width conversion and no sign handling.

Decomposition:
- Package rtop_pkg holds:
  - the state encoding constants ST_IDLE=2'b00, ST_CONV=2'b01, ST_HOLD=2'b10;
  - the operand width (4) and result width (8) constants.
- Sub-module rr_arbiter (NREQ): inputs req vector, rr_ptr and enable; outputs one-hot grant and encoded index. It is purely combinational.
- RtoPF is instantiated unchanged, once, inside rtop_scheduler.

Test Plan:
1. Reset: hold RST low with req_valid=4'b1111. Required: req_ready=0, res_valid=0, busy=0, res_mag=0. After release, the first grant is requester 0.
2. Single request: requester 2 drives X=3, Y=4, CONV_LAT=1. Required:
   - req_ready[2] pulses for one cycle;
   - res_valid rises 1 edge after the accept edge;
   - res_id=2, res_mag=5, res_angle equals the RtoPF golden value for (3,4).
3. Round robin: all four requesters valid continuously with distinct operands and res_ready=1. Required: grant sequence 0,1,2,3,0,1, each result matching its own operands.
4. Backpressure: res_ready=0 for 10 cycles after res_valid rises. Required:
   - res_* stay stable;
   - req_ready stays 0 even though requester 1 is valid;
   - the accept for requester 1 occurs one cycle after res_ready goes high.
5. CONV_LAT=3: single request X=15, Y=0. Required: res_valid 3 edges after accept, res_mag=15.
6. Reset mid-CONV: drive RST low during CONV. Required: res_valid is never asserted for the aborted request. After release, rr_ptr=0 and arbitration restarts from requester 0.
